// File: rtl/lane_align_buffer.sv
// lane_align_buffer: multi-lane receive alignment buffer.
// Each lane has its own FIFO. The lanes are released only after every lane holds
// data and a programmable hold delay has elapsed. After release, all lanes are
// popped in lock-step.
// Ports:
//   Clock, Reset_N       clock and asynchronous active-low reset
//   Write_Data/Enable    per-lane words and write strobes (lane i at [i*DATA_W +: DATA_W])
//   Read_Enable          consumer request for one aligned word set
//   Resync               synchronous flush and re-align request
//   Read_Data/Valid      registered aligned word set and its valid flag
//   Aligned              high while in RUN
//   Empty_For_NonAll     some lanes are empty and some are not (decoded from the counts)
//   Full_Any             some lane holds DEPTH words (decoded from the counts)
//   Overflow_Error       sticky per lane; a write to a full lane was dropped
//   Underflow_Error      sticky; a read in RUN found an empty lane
module lane_align_buffer #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned RELEASE_DELAY = 0
) (
    input  logic                    Clock,
    input  logic                    Reset_N,
    input  logic [LANES*DATA_W-1:0] Write_Data,
    input  logic [LANES-1:0]        Write_Enable,
    input  logic                    Read_Enable,
    input  logic                    Resync,
    output logic [LANES*DATA_W-1:0] Read_Data,
    output logic                    Read_Valid,
    output logic                    Aligned,
    output logic                    Empty_For_NonAll,
    output logic                    Full_Any,
    output logic [LANES-1:0]        Overflow_Error,
    output logic                    Underflow_Error
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DLY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [DLY_W-1:0]    dly_cnt, dly_cnt_next;

    logic [DATA_W-1:0]   mem        [LANES][DEPTH];
    logic [AW-1:0]       wr_ptr     [LANES];
    logic [AW-1:0]       rd_ptr     [LANES];
    logic [CW-1:0]       count      [LANES];
    logic [CW-1:0]       count_next [LANES];

    logic                all_nonempty, any_nonempty, any_full, all_next_nonempty;
    logic                pop, underflow, flush;
    logic [LANES-1:0]    wr_ok, wr_drop;

    // Lane status decoded from the count registers only
    always_comb begin
        all_nonempty = 1'b1;
        any_nonempty = 1'b0;
        any_full     = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (count[i] == '0) all_nonempty = 1'b0;
            else                any_nonempty = 1'b1;
            if (count[i] == CW'(DEPTH)) any_full = 1'b1;
        end
    end

    assign pop       = (state == RUN) && Read_Enable && all_nonempty && !Resync;
    assign underflow = (state == RUN) && Read_Enable && !all_nonempty && !Resync;
    assign flush     = Resync || underflow;

    assign Empty_For_NonAll = !all_nonempty && any_nonempty;
    assign Full_Any         = any_full;

    // Write acceptance and next occupancy; a pop frees the slot a full lane needs
    always_comb begin
        wr_ok             = '0;
        wr_drop           = '0;
        all_next_nonempty = 1'b1;
        for (int i = 0; i < int'(LANES); i++) begin
            count_next[i] = count[i];
            wr_ok[i]      = Write_Enable[i] && !flush && ((count[i] < CW'(DEPTH)) || pop);
            wr_drop[i]    = Write_Enable[i] && !flush && !wr_ok[i];
            if (flush)
                count_next[i] = '0;
            else if (wr_ok[i] && !pop)
                count_next[i] = count[i] + CW'(1);
            else if (!wr_ok[i] && pop)
                count_next[i] = count[i] - CW'(1);
            if (count_next[i] == '0) all_next_nonempty = 1'b0;
        end
    end

    // Next-state logic; IDLE looks at the post-write counts so HOLD starts
    // in the first cycle every lane holds data
    always_comb begin
        state_next   = state;
        dly_cnt_next = dly_cnt;
        case (state)
            IDLE: begin
                dly_cnt_next = '0;
                if (all_next_nonempty) state_next = HOLD;
            end
            HOLD: begin
                if (all_nonempty) begin
                    if (dly_cnt == DLY_W'(RELEASE_DELAY)) state_next = RUN;
                    else dly_cnt_next = dly_cnt + DLY_W'(1);
                end
            end
            RUN: begin
                if (underflow) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (Resync) begin
            state_next   = IDLE;
            dly_cnt_next = '0;
        end
    end

    // State, pointers, counts and registered outputs
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state           <= IDLE;
            dly_cnt         <= '0;
            Read_Data       <= '0;
            Read_Valid      <= 1'b0;
            Aligned         <= 1'b0;
            Overflow_Error  <= '0;
            Underflow_Error <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            state      <= state_next;
            dly_cnt    <= dly_cnt_next;
            Read_Valid <= pop;
            Aligned    <= (state_next == RUN);
            for (int i = 0; i < int'(LANES); i++) begin
                count[i] <= count_next[i];
                if (flush) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end else begin
                    if (wr_ok[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                    if (pop)      rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                if (pop) Read_Data[i*DATA_W +: DATA_W] <= mem[i][rd_ptr[i]];
            end
            if (Resync) begin
                Overflow_Error  <= '0;
                Underflow_Error <= 1'b0;
            end else begin
                Overflow_Error <= Overflow_Error | wr_drop;
                if (underflow) Underflow_Error <= 1'b1;
            end
        end
    end

    // Lane storage; contents need no reset
    always_ff @(posedge Clock) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_ok[i]) mem[i][wr_ptr[i]] <= Write_Data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: doc/lane_align_buffer.md
# lane_align_buffer

Parametrised multi-lane alignment buffer for the JESD-style receive path. It sits between the per-lane receive controllers (which deliver descrambled octets with per-lane write strobes) and the sample-composition stage. Each lane has its own FIFO. Lanes are released only after every lane holds data plus a programmable release delay, which absorbs inter-lane skew up to DEPTH words. After release, all lanes are read in lock-step, with overflow and underflow detection and a synchronous resync.

## Interface
Parameters:
- LANES, 4, number of lanes (1..8)
- DATA_W, 8, bits per lane word
- DEPTH, 16, words per lane FIFO; power of two, 4..256
- RELEASE_DELAY, 0, extra cycles in HOLD after all lanes become non-empty (0..255)

Ports:
- Clock  in  1  single clock for all logic
- Reset_N  in  1  asynchronous, active-low reset
- Write_Data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- Write_Enable  in  LANES  per-lane write strobe
- Read_Enable  in  1  consumer request for one aligned word set
- Resync  in  1  synchronous flush and re-align request
- Read_Data  out  LANES*DATA_W  registered aligned word set
- Read_Valid  out  1  Read_Data valid this cycle
- Aligned  out  1  high in RUN state
- Empty_For_NonAll  out  1  at least one lane empty while at least one lane is non-empty
- Full_Any  out  1  at least one lane holds DEPTH words
- Overflow_Error  out  LANES  sticky; write to a full lane was dropped
- Underflow_Error  out  1  sticky; read requested in RUN while a lane was empty

## Operation
- Per lane: RAM of DEPTH x DATA_W, write/read pointers of log2(DEPTH) bits wrapping modulo DEPTH, and an occupancy count of log2(DEPTH)+1 bits.
- Write to lane i: accepted when Write_Enable[i]=1 and either count<DEPTH or a read of that lane occurs in the same cycle. Otherwise the word is dropped and Overflow_Error[i] is set.
- Same-cycle read and write on a lane: both take effect and the count is unchanged.
- Writes are accepted in every state. Reads happen only in RUN.
- State machine (reset state IDLE):
  - IDLE: if every count>=1, go to HOLD and clear the delay counter.
  - HOLD: if delay counter==RELEASE_DELAY, go to RUN; else increment the counter. HOLD lasts RELEASE_DELAY+1 cycles. If any lane empties (impossible without reads), stay put.
  - RUN:
    - Read_Enable=1 and all counts>=1: pop every lane at the same time.
    - Read_Enable=1 and any lane empty: no pop, set Underflow_Error, flush all lanes (pointers and counts to 0), go to IDLE.
    - Read_Enable=0: hold.
- Resync=1 has the highest priority. It zeroes all pointers and counts, clears all error bits, forces IDLE and Read_Valid=0, and ignores same-cycle writes.
- Empty_For_NonAll and Full_Any are decoded combinationally from the count registers only.

## Timing
- All outputs reset to 0: Read_Data, Read_Valid, Aligned, Empty_For_NonAll, Full_Any, Overflow_Error, Underflow_Error.
- Write-to-visible latency: a word written in cycle n counts as present in cycle n+1.
- Minimum write-to-release latency: all lanes written in cycle n gives HOLD at n+1 and RUN (Aligned=1) at n+2+RELEASE_DELAY.
- Read latency: a pop in cycle n gives Read_Data and Read_Valid=1 in cycle n+1. Read_Valid=0 in any cycle following a cycle without a pop.
- Read_Data holds its last value when Read_Valid=0.
- Underflow: Aligned drops in the cycle after the failed request. Underflow_Error is high from that cycle.
- Resync asserted in cycle n: Aligned=0, Read_Valid=0 and error bits clear from n+1. Lanes are empty at n+1.
- Asynchronous reset mid-operation: all state cleared immediately. RAM contents are don't-care.
- Pointer wrap: after DEPTH pops, the pointer returns to 0 with no data loss.

## Test plan
- Skew absorption (LANES=4, RELEASE_DELAY=2): lane 0 writes 0x10,0x11,… starting at cycle 0; lanes 1-3 write the same sequence starting 3 cycles later.
  - Aligned rises at cycle 3+1+1+2=7.
  - With Read_Enable=1, the first Read_Data is 0x10101010 and later words follow in lock-step.
- Overflow: fill lane 2 with 16 words (DEPTH=16), then write a 17th without a read.
  - Overflow_Error=4'b0100, Full_Any=1, count stays 16, data order intact.
- Underflow: in RUN, drain lane 1 to empty while lanes 0/2/3 hold 3 words, then assert Read_Enable.
  - Next cycle: Underflow_Error=1, Aligned=0, Read_Valid=0, all counts 0.
- Resync during RUN with lanes half full and errors set.
  - Next cycle: everything is cleared.
  - Re-alignment then occurs from fresh writes only.
- Continuous streaming at 100% read/write rate for 3*DEPTH words:
  - no errors;
  - counts constant;
  - pointer wrap is seamless;
  - Empty_For_NonAll stays 0.
- Reset_N pulsed low mid-stream: all outputs are 0 immediately, and the block re-aligns normally after release.
